// File: rtl/gshare_bht.sv
// gshare branch history table: 2^INDEX_BITS saturating counters indexed by PC ^ global history (GSHARE_BHT_XOR_EN), else bimodal.
// Latency: prediction combinational; counter/GHR written at the update edge; mispredict_o one cycle later; init sweep 2^INDEX_BITS cycles.
// Backpressure: none; lookups and updates are ignored while ready_o is low.
module gshare_bht #(
    parameter int INDEX_BITS = 8,
    parameter int CNT_BITS   = 2,
    parameter int GHR_BITS   = 8,
    parameter int PC_LSB     = 2
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    output logic                pred_taken_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [31:0]         upd_pc_i,
    input  logic                upd_taken_i,
    input  logic                upd_pred_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    output logic                mispredict_o,
    output logic                ready_o
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] sweep;
    logic [CNT_BITS-1:0]   cnt_tbl [DEPTH];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CNT_BITS-1:0]   upd_cnt;
    logic [CNT_BITS-1:0]   upd_cnt_nxt;
    logic                  run;
    logic                  mispredict;
    logic                  unused_pc;

    assign run        = (state == RUN);
    assign ready_o    = run;
    assign mispredict = run && upd_valid_i && (upd_taken_i != upd_pred_i);
    assign unused_pc  = &{1'b0, pred_pc_i, upd_pc_i};

`ifdef GSHARE_BHT_XOR_EN
    logic [GHR_BITS-1:0] ghr;

    assign pred_idx   = pred_pc_i[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(ghr);
    assign upd_idx    = upd_pc_i[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(upd_ghr_i);
    assign pred_ghr_o = ghr;

    // Repair wins over the speculative shift: the front end is being flushed.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= GHR_BITS'({upd_ghr_i, upd_taken_i});
        end else if (run && pred_valid_i) begin
            ghr <= GHR_BITS'({ghr, pred_taken_o});
        end
    end
`else
    logic unused_ghr;

    assign pred_idx   = pred_pc_i[PC_LSB+INDEX_BITS-1:PC_LSB];
    assign upd_idx    = upd_pc_i[PC_LSB+INDEX_BITS-1:PC_LSB];
    assign pred_ghr_o = '0;
    assign unused_ghr = &{1'b0, upd_ghr_i, pred_valid_i};
`endif

    assign pred_taken_o = run & cnt_tbl[pred_idx][CNT_BITS-1];
    assign upd_cnt      = cnt_tbl[upd_idx];

    always_comb begin
        upd_cnt_nxt = upd_cnt;
        if (upd_taken_i && (upd_cnt != '1)) begin
            upd_cnt_nxt = upd_cnt + CNT_BITS'(1);
        end else if (!upd_taken_i && (upd_cnt != '0)) begin
            upd_cnt_nxt = upd_cnt - CNT_BITS'(1);
        end
    end

    // Storage has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            cnt_tbl[sweep] <= CNT_INIT;
        end else if (upd_valid_i) begin
            cnt_tbl[upd_idx] <= upd_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state        <= INIT;
            sweep        <= '0;
            mispredict_o <= 1'b0;
        end else begin
            mispredict_o <= mispredict;
            case (state)
                INIT: begin
                    sweep <= sweep + INDEX_BITS'(1);
                    if (sweep == '1) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
